// File: rtl/cordic_wrapper.sv
// cordic_wrapper: byte-serial vectoring CORDIC (magnitude + atan2) user module.
// Ports: clk, rst_n (sync, active-low), ena (unused), ui_in (data in), uo_out (data out),
//   uio_in[0] in_valid, uio_in[3] out_ready, uio_out[1] in_ready, uio_out[2] out_valid,
//   uio_oe constant 8'h06.
module cordic_wrapper #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_COMP = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam int         XW     = WIDTH + 2;
    localparam logic [5:0] LAST   = 6'(WIDTH + 1);

    logic [1:0]           state;
    logic [2:0]           cnt;
    logic [5:0]           step;
    logic [WIDTH-1:0]     xin, yin;
    logic signed [XW-1:0] x, y;
    logic [31:0]          z;
    logic [3:0]           sh;
    logic [15:0]          mag;
    logic [31:0]          phase;

    logic in_valid, out_ready, in_ready, out_valid;

    assign in_valid  = uio_in[0];
    assign out_ready = uio_in[3];
    assign in_ready  = rst_n & (state == S_LOAD);
    assign out_valid = rst_n & (state == S_OUT);

    assign uio_out = {5'b0, out_valid, in_ready, 1'b0};
    assign uio_oe  = 8'b0000_0110;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:4], uio_in[2:1]};

    function automatic logic [31:0] atan_lut(input logic [5:0] i);
        unique case (i)
            6'd0:    atan_lut = 32'h2000_0000;
            6'd1:    atan_lut = 32'h12E4_051E;
            6'd2:    atan_lut = 32'h09FB_385B;
            6'd3:    atan_lut = 32'h0511_11D4;
            6'd4:    atan_lut = 32'h028B_0D43;
            6'd5:    atan_lut = 32'h0145_D7E1;
            6'd6:    atan_lut = 32'h00A2_F61E;
            6'd7:    atan_lut = 32'h0051_7C55;
            6'd8:    atan_lut = 32'h0028_BE53;
            6'd9:    atan_lut = 32'h0014_5F2F;
            6'd10:   atan_lut = 32'h000A_2F98;
            6'd11:   atan_lut = 32'h0005_17CC;
            6'd12:   atan_lut = 32'h0002_8BE6;
            6'd13:   atan_lut = 32'h0001_45F3;
            6'd14:   atan_lut = 32'h0000_A2FA;
            6'd15:   atan_lut = 32'h0000_517D;
            default: atan_lut = 32'h0000_0000;
        endcase
    endfunction

    // Left shift that brings the larger component into [2^14, 2^15).
    function automatic logic [3:0] norm_shift(input logic [WIDTH-1:0] m);
        logic [3:0] s;
        s = 4'd0;
        for (int k = 0; k < WIDTH - 1; k++) begin
            if (m[k]) s = 4'(WIDTH - 2 - k);
        end
        return s;
    endfunction

    // Small vectors are shifted up before iterating so the truncating
    // shifts keep enough precision; the magnitude is shifted back at the end.
    logic [WIDTH-1:0]     ax, ay;
    logic [3:0]           nsh;
    logic signed [XW-1:0] xs, ys;
    logic [5:0]           it;
    logic [35:0]          rnd;
    logic [15:0]          mag_calc;
    logic                 is_zero;

    assign ax       = xin[WIDTH-1] ? -xin : xin;
    assign ay       = yin[WIDTH-1] ? -yin : yin;
    assign nsh      = norm_shift(ax | ay);
    assign xs       = {{2{xin[WIDTH-1]}}, xin} <<< nsh;
    assign ys       = {{2{yin[WIDTH-1]}}, yin} <<< nsh;
    assign it       = step - 6'd1;
    assign rnd      = {{(36-XW){1'b0}}, x} * 36'd39797
                    + (36'd1 << (5'(sh) + 5'd15));
    assign mag_calc = 16'(rnd >> (6'(sh) + 6'd16));
    assign is_zero  = (xin == '0) && (yin == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_LOAD;
            cnt   <= 3'd0;
            step  <= 6'd0;
            xin   <= '0;
            yin   <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            sh    <= '0;
            mag   <= '0;
            phase <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        unique case (cnt)
                            3'd0:    xin[7:0]  <= ui_in;
                            3'd1:    xin[15:8] <= ui_in;
                            3'd2:    yin[7:0]  <= ui_in;
                            default: yin[15:8] <= ui_in;
                        endcase
                        if (cnt == 3'd3) begin
                            cnt   <= 3'd0;
                            step  <= 6'd0;
                            state <= S_COMP;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                S_COMP: begin
                    step <= step + 6'd1;
                    unique case (1'b1)
                        (step == 6'd0): begin
                            // +pi and -pi share the encoding 0x8000_0000.
                            x  <= xin[WIDTH-1] ? -xs : xs;
                            y  <= xin[WIDTH-1] ? -ys : ys;
                            z  <= xin[WIDTH-1] ? 32'h8000_0000 : 32'h0;
                            sh <= nsh;
                        end
                        (step == LAST): begin
                            mag   <= is_zero ? 16'd0 : mag_calc;
                            phase <= is_zero ? 32'd0 : z;
                            cnt   <= 3'd0;
                            state <= S_OUT;
                        end
                        default: begin
                            if (!y[XW-1]) begin
                                x <= x + (y >>> it);
                                y <= y - (x >>> it);
                                z <= z + atan_lut(it);
                            end else begin
                                x <= x - (y >>> it);
                                y <= y + (x >>> it);
                                z <= z - atan_lut(it);
                            end
                        end
                    endcase
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (cnt == 3'd5) begin
                            cnt   <= 3'd0;
                            state <= S_LOAD;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    always_comb begin
        uo_out = 8'h00;
        if (out_valid) begin
            unique case (cnt)
                3'd0:    uo_out = mag[7:0];
                3'd1:    uo_out = mag[15:8];
                3'd2:    uo_out = phase[7:0];
                3'd3:    uo_out = phase[15:8];
                3'd4:    uo_out = phase[23:16];
                3'd5:    uo_out = phase[31:24];
                default: uo_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_wrapper.sv
// tb_cordic_wrapper: directed vector bench for cordic_wrapper.
// Table of (X, Y) -> (magnitude, phase) plus reset/backpressure sequences.
module tb_cordic_wrapper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       in_valid;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;

    always #5 clk = ~clk;

    assign uio_in    = {4'b0, out_ready, 2'b0, in_valid};
    assign in_ready  = uio_out[1];
    assign out_valid = uio_out[2];

    cordic_wrapper #(.WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] mag;
        logic [31:0] ph;
        int          mtol;
        int          ptol;
    } vec_t;

    vec_t vt[8];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   excl_bad = 0;

    always @(negedge clk) begin
        if (in_ready && out_valid) excl_bad <= excl_bad + 1;
    end

    task automatic chk(input string name, input bit ok,
                       input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ui_in    = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ui_in    = 8'h00;
    endtask

    task automatic send_xy(input logic [15:0] xv, input logic [15:0] yv);
        send_byte(xv[7:0]);
        send_byte(xv[15:8]);
        send_byte(yv[7:0]);
        send_byte(yv[15:8]);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic read_bytes(input int n, input bit keep,
                              output logic [47:0] bytes, output bit ok);
        bytes = '0;
        ok    = 1'b1;
        for (int k = 0; k < n; k++) begin
            ok = ok & out_valid;
            bytes[8*k +: 8] = uo_out;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            if (!keep) out_ready = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic check_res(input int i, input logic [47:0] bytes);
        int                 dm;
        logic signed [31:0] dp;
        dm = int'(bytes[15:0]) - int'(vt[i].mag);
        dp = $signed(bytes[47:16] - vt[i].ph);
        chk($sformatf("v%0d mag", i), dm <= vt[i].mtol && dm >= -vt[i].mtol,
            longint'(bytes[15:0]), longint'(vt[i].mag));
        chk($sformatf("v%0d phase", i), dp <= vt[i].ptol && dp >= -vt[i].ptol,
            longint'(bytes[47:16]), longint'(vt[i].ph));
    endtask

    task automatic do_vec(input int i, input bit keep, input bit junk);
        int          lat;
        logic [47:0] bytes;
        bit          ok;
        if (keep) out_ready = 1'b1;
        send_xy(vt[i].x, vt[i].y);
        if (junk) begin
            ui_in    = 8'hA5;
            in_valid = 1'b1;
        end
        wait_valid(lat);
        in_valid = 1'b0;
        ui_in    = 8'h00;
        chk($sformatf("v%0d latency", i), lat == 18, lat, 18);
        read_bytes(6, keep, bytes, ok);
        chk($sformatf("v%0d valid held", i), ok, ok, 1);
        check_res(i, bytes);
        chk($sformatf("v%0d in_ready after", i), in_ready == 1'b1, in_ready, 1);
    endtask

    initial begin
        int          lat;
        int          bad;
        logic [7:0]  b0;
        logic [47:0] bytes;
        bit          ok;

        vt[0] = '{16'd13604, 16'd24193, 16'd27756, 32'h2B21_1CDE, 4, 65536};
        vt[1] = '{-16'sd100, 16'd0, 16'd100, 32'h8000_0000, 4, 65536};
        vt[2] = '{16'd0, -16'sd100, 16'd100, 32'hC000_0000, 4, 65536};
        vt[3] = '{16'd0, 16'd100, 16'd100, 32'h4000_0000, 4, 65536};
        vt[4] = '{16'h8000, 16'h8000, 16'd46341, 32'hA000_0000, 4, 65536};
        vt[5] = '{16'd0, 16'd0, 16'd0, 32'h0000_0000, 0, 0};
        vt[6] = '{16'd1000, -16'sd1000, 16'd1414, 32'hE000_0000, 4, 65536};
        vt[7] = '{-16'sd5000, 16'd12000, 16'd13000, 32'h5015_D21B, 4, 65536};

        rst_n     = 1'b0;
        ena       = 1'b1;
        ui_in     = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (uo_out != 8'h00 || uio_out != 8'h00) bad++;
        end
        chk("reset outputs zero", bad == 0, bad, 0);
        chk("uio_oe", uio_oe == 8'h06, uio_oe, 8'h06);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", in_ready == 1'b1, in_ready, 1);
        chk("out_valid after reset", out_valid == 1'b0, out_valid, 0);
        chk("uo_out idle", uo_out == 8'h00, uo_out, 0);

        for (int i = 0; i < 8; i++) begin
            if (i != 6) do_vec(i, i == 3, i == 1);
        end

        send_xy(vt[6].x, vt[6].y);
        ui_in    = 8'h5A;
        in_valid = 1'b1;
        wait_valid(lat);
        in_valid = 1'b0;
        ui_in    = 8'h00;
        chk("bp latency", lat == 18, lat, 18);
        b0  = uo_out;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (uo_out != b0 || !out_valid || in_ready) bad++;
        end
        chk("bp hold stable", bad == 0, bad, 0);
        read_bytes(6, 1'b0, bytes, ok);
        chk("bp valid held", ok, ok, 1);
        check_res(6, bytes);

        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid-load reset in_ready", in_ready == 1'b0, in_ready, 0);
        rst_n = 1'b1;
        do_vec(0, 1'b0, 1'b0);

        send_xy(vt[2].x, vt[2].y);
        wait_valid(lat);
        read_bytes(3, 1'b0, bytes, ok);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid-out reset out_valid", out_valid == 1'b0, out_valid, 0);
        do_vec(7, 1'b0, 1'b0);

        chk("ready/valid exclusive", excl_bad == 0, excl_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
